// File: rtl/demux_2_buffered.sv
// Steers one valid/ready input stream to one of two consumers.
// Each consumer has its own FIFO, so backpressure on one side never blocks the other.
module demux_2_buffered #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] Data_in,
  input  logic             sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Data_out1,
  output logic             out_valid1,
  input  logic             out_ready1,
  output logic [WIDTH-1:0] Data_out2,
  output logic             out_valid2,
  input  logic             out_ready2,
  output logic [CW-1:0]    Count1,
  output logic [CW-1:0]    Count2
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0]    wr_ptr_q [2];
  logic [PW-1:0]    wr_ptr_d [2];
  logic [PW-1:0]    rd_ptr_q [2];
  logic [PW-1:0]    rd_ptr_d [2];
  logic [CW-1:0]    count_q  [2];
  logic [CW-1:0]    count_d  [2];
  logic [WIDTH-1:0] mem_q    [2][DEPTH];

  logic [1:0] full;
  logic [1:0] push;
  logic [1:0] pop;

  // Status and handshakes; in_ready looks only at registered occupancy, never at out_ready.
  always_comb begin
    full[0]    = (count_q[0] == CW'(DEPTH));
    full[1]    = (count_q[1] == CW'(DEPTH));
    out_valid1 = (count_q[0] != '0);
    out_valid2 = (count_q[1] != '0);
    in_ready   = rst_n && !full[sel];
    push[0]    = in_valid && in_ready && !sel;
    push[1]    = in_valid && in_ready && sel;
    pop[0]     = out_valid1 && out_ready1;
    pop[1]     = out_valid2 && out_ready2;
    Count1     = count_q[0];
    Count2     = count_q[1];
  end

  // Heads are forced to zero while empty so stale storage never leaks out.
  always_comb begin
    Data_out1 = '0;
    Data_out2 = '0;
    if (out_valid1) Data_out1 = mem_q[0][rd_ptr_q[0]];
    if (out_valid2) Data_out2 = mem_q[1][rd_ptr_q[1]];
  end

  // Pointer and occupancy next-state; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      count_d[i]  = count_q[i];
      if (push[i]) wr_ptr_d[i] = wr_ptr_q[i] + PW'(1);
      if (pop[i])  rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
      case ({push[i], pop[i]})
        2'b10:   count_d[i] = count_q[i] + CW'(1);
        2'b01:   count_d[i] = count_q[i] - CW'(1);
        default: count_d[i] = count_q[i];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        count_q[i]  <= count_d[i];
      end
    end
  end

  // Storage is deliberately left unreset; a push is already blocked while rst_n is low.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= Data_in;
    end
  end

endmodule

// File: tb/tb_demux_2_buffered.sv
// Bench for demux_2_buffered: queue-based reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_demux_2_buffered;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] Data_in;
  logic             sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] Data_out1;
  logic             out_valid1;
  logic             out_ready1;
  logic [WIDTH-1:0] Data_out2;
  logic             out_valid2;
  logic             out_ready2;
  logic [CW-1:0]    Count1;
  logic [CW-1:0]    Count2;

  demux_2_buffered #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .Data_in(Data_in), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .Data_out1(Data_out1), .out_valid1(out_valid1),
    .out_ready1(out_ready1), .Data_out2(Data_out2), .out_valid2(out_valid2),
    .out_ready2(out_ready2), .Count1(Count1), .Count2(Count2)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  logic [WIDTH-1:0] q1[$];
  logic [WIDTH-1:0] q2[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: two bounded queues updated from the handshakes seen at each edge.
  always @(posedge clk) begin
    bit m_push, m_pop1, m_pop2;
    if (!rst_n) begin
      q1.delete();
      q2.delete();
    end else begin
      m_push = in_valid && (sel ? (q2.size() < DEPTH) : (q1.size() < DEPTH));
      m_pop1 = out_ready1 && (q1.size() > 0);
      m_pop2 = out_ready2 && (q2.size() > 0);
      if (m_pop1) q1.delete(0);
      if (m_pop2) q2.delete(0);
      if (m_push) begin
        if (sel) q2.push_back(Data_in);
        else     q1.push_back(Data_in);
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (check_en) begin
      check("m_in_ready", {31'd0, in_ready},
            {31'd0, rst_n && (sel ? (q2.size() < DEPTH) : (q1.size() < DEPTH))});
      check("m_valid1", {31'd0, out_valid1}, {31'd0, q1.size() != 0});
      check("m_valid2", {31'd0, out_valid2}, {31'd0, q2.size() != 0});
      check("m_data1", Data_out1, (q1.size() != 0) ? q1[0] : 32'd0);
      check("m_data2", Data_out2, (q2.size() != 0) ? q2[0] : 32'd0);
      check("m_count1", 32'(Count1), 32'(q1.size()));
      check("m_count2", 32'(Count2), 32'(q2.size()));
      check("count1_le_depth", {31'd0, 32'(Count1) <= DEPTH}, 32'd1);
      check("count2_le_depth", {31'd0, 32'(Count2) <= DEPTH}, 32'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [WIDTH-1:0] received[$];

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; sel = 1'b0; Data_in = 32'hDEAD_BEEF;
    out_ready1 = 1'b0; out_ready2 = 1'b0;

    // 1. Reset held three cycles with in_valid high
    tick(); check_en = 1'b1;
    tick(); tick(); settle();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_valid1", {31'd0, out_valid1}, 32'd0);
    check("rst_valid2", {31'd0, out_valid2}, 32'd0);
    check("rst_data1", Data_out1, 32'd0);
    check("rst_data2", Data_out2, 32'd0);
    check("rst_count1", 32'(Count1), 32'd0);
    check("rst_count2", 32'(Count2), 32'd0);
    rst_n = 1'b1; in_valid = 1'b0; settle();
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // 2. Basic steering
    tick();
    out_ready1 = 1'b1; out_ready2 = 1'b1;
    in_valid = 1'b1; sel = 1'b0; Data_in = 32'hAAAA_0001;
    tick();
    sel = 1'b1; Data_in = 32'hBBBB_0002; settle();
    check("steer_v1", {31'd0, out_valid1}, 32'd1);
    check("steer_d1", Data_out1, 32'hAAAA_0001);
    check("steer_v2_early", {31'd0, out_valid2}, 32'd0);
    tick();
    in_valid = 1'b0; settle();
    check("steer_v1_once", {31'd0, out_valid1}, 32'd0);
    check("steer_v2", {31'd0, out_valid2}, 32'd1);
    check("steer_d2", Data_out2, 32'hBBBB_0002);
    tick();
    check("steer_v2_once", {31'd0, out_valid2}, 32'd0);

    // 3. Backpressure isolation
    out_ready1 = 1'b0;
    in_valid = 1'b1; sel = 1'b0; Data_in = 32'h11;
    tick();
    Data_in = 32'h22;
    tick();
    Data_in = 32'h44; settle();
    check("bp_count1", 32'(Count1), 32'd2);
    check("bp_in_ready_sel0", {31'd0, in_ready}, 32'd0);
    sel = 1'b1; Data_in = 32'h33; settle();
    check("bp_in_ready_sel1", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0; settle();
    check("bp_d2", Data_out2, 32'h33);
    check("bp_count1_hold", 32'(Count1), 32'd2);
    out_ready1 = 1'b1; settle();
    check("bp_first", Data_out1, 32'h11);
    tick();
    check("bp_second", Data_out1, 32'h22);
    tick();
    check("bp_drained", {31'd0, out_valid1}, 32'd0);

    // 4. Full FIFO with simultaneous pop: push refused, accepted next cycle
    out_ready1 = 1'b0;
    in_valid = 1'b1; sel = 1'b0; Data_in = 32'h41;
    tick();
    Data_in = 32'h42;
    tick();
    Data_in = 32'h43; out_ready1 = 1'b1; settle();
    check("full_count_2", 32'(Count1), 32'd2);
    check("full_refuse", {31'd0, in_ready}, 32'd0);
    tick();
    out_ready1 = 1'b0; settle();
    check("full_count_1", 32'(Count1), 32'd1);
    check("full_accept", {31'd0, in_ready}, 32'd1);
    check("full_head", Data_out1, 32'h42);
    tick();
    in_valid = 1'b0; settle();
    check("full_count_2b", 32'(Count1), 32'd2);
    check("full_head_b", Data_out1, 32'h42);
    out_ready1 = 1'b1;
    tick(); tick();
    check("full_drained", 32'(Count1), 32'd0);

    // 5. Wrap-around stream with random consumer stalls
    begin
      int sent = 0;
      int cycles = 0;
      bit acc;
      bit stalled = 1'b0;
      logic [WIDTH-1:0] prev = '0;
      sel = 1'b0;
      while ((sent < 10 || received.size() < 10) && cycles < 300) begin
        in_valid = (sent < 10);
        Data_in = 32'h100 + 32'(sent);
        out_ready1 = 1'($urandom_range(0, 1));
        settle();
        if (stalled) check("wrap_stable", Data_out1, prev);
        acc = in_valid && in_ready;
        if (out_valid1 && out_ready1) received.push_back(Data_out1);
        stalled = out_valid1 && !out_ready1;
        prev = Data_out1;
        tick();
        if (acc) sent++;
        cycles++;
      end
      in_valid = 1'b0;
      check("wrap_timeout", {31'd0, cycles < 300}, 32'd1);
      check("wrap_count", 32'(received.size()), 32'd10);
      for (int i = 0; i < 10 && i < received.size(); i++)
        check("wrap_order", received[i], 32'h100 + 32'(i));
    end

    // 6. Reset mid-operation discards buffered words
    out_ready1 = 1'b0; out_ready2 = 1'b0;
    in_valid = 1'b1; sel = 1'b0; Data_in = 32'h61;
    tick();
    Data_in = 32'h62;
    tick();
    sel = 1'b1; Data_in = 32'h71;
    tick();
    in_valid = 1'b0; settle();
    check("mid_count1", 32'(Count1), 32'd2);
    check("mid_count2", 32'(Count2), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; settle();
    check("mid_rst_count1", 32'(Count1), 32'd0);
    check("mid_rst_count2", 32'(Count2), 32'd0);
    check("mid_rst_v1", {31'd0, out_valid1}, 32'd0);
    check("mid_rst_v2", {31'd0, out_valid2}, 32'd0);
    in_valid = 1'b1; sel = 1'b1; Data_in = 32'h5; out_ready2 = 1'b1;
    tick();
    in_valid = 1'b0; settle();
    check("mid_d2", Data_out2, 32'h5);
    check("mid_count2_one", 32'(Count2), 32'd1);
    check("mid_v1_idle", {31'd0, out_valid1}, 32'd0);
    tick();
    check("mid_v2_done", {31'd0, out_valid2}, 32'd0);

    tick();
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
